io_bus_bridge: RTL and testbench
================================

Name: io_bus_bridge

Overview:
- Memory-mapped bridge directly downstream of the CPU data bus, between the core and data memory / board I/O.
- Decodes each CPU data access to DRAM, LEDs, switches, buttons, an 8-digit seven-segment display or an interval timer, and returns read data to the core in the same cycle.
- Contains the display scan engine, the timer/prescaler and the input synchronisers.

Parameters:
- SCAN_DIV, 20000: cpu_clk cycles each display digit stays lit; legal range >= 2.
- TIMER_DIV, 1: cpu_clk cycles per timer count; legal range >= 1.

Ports:
- cpu_clk  in  1  system clock; all state updates on the rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- Bus_addr  in  32  CPU data address (byte address).
- Bus_wen  in  1  CPU write enable.
- Bus_wdata  in  32  CPU write data.
- Bus_rdata  out  32  read data to CPU, combinational.
- dram_addr  out  14  word address to DRAM; equals Bus_addr[15:2].
- dram_wen  out  1  DRAM write enable.
- dram_wdata  out  32  DRAM write data; equals Bus_wdata.
- dram_rdata  in  32  DRAM asynchronous read data.
- sw  in  24  board switches, asynchronous.
- btn  in  5  board buttons, asynchronous.
- led  out  24  LED outputs, 1 = lit.
- dig_en  out  8  digit enables, active low.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Address decode (full 32-bit compare for I/O):
  - 0xFFFFF000 = DIG (rw)
  - 0xFFFFF020 = TIMER (rw)
  - 0xFFFFF024 = TDIV_CNT (r)
  - 0xFFFFF060 = LED (rw)
  - 0xFFFFF070 = SW (r)
  - 0xFFFFF078 = BTN (r)
  - Any other address with [31:12] = 0xFFFFF is unmapped: reads return 0, writes are ignored.
  - All other addresses go to DRAM.
- dram_wen = Bus_wen only when the access decodes to DRAM; otherwise 0.
- Reads are zero latency: Bus_rdata is a pure mux of dram_rdata and the registered/synchronised values in the current cycle. Narrow registers are zero-extended.
- Writes take effect at the next rising edge; a read of the same register in the write cycle returns the old value.
- Reset values (one edge with cpu_rst=1):
  - DIG = 0, LED = 0, TIMER = 0, prescaler = 0, scan counter = 0, digit index = 0.
  - Synchroniser flops = 0.
  - Outputs after reset: led = 0, dig_en = 8'hFE, seg = pattern for hex 0 (8'hC0).
- Inputs: sw and btn each pass through a 2-flop synchroniser. SW/BTN reads show the second flop, so an input change is visible on the bus 2 edges later.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1 and wraps.
  - When the prescaler is at TIMER_DIV-1, TIMER increments by 1 (mod 2^32; 0xFFFFFFFF wraps to 0).
  - A CPU write to TIMER loads Bus_wdata and clears the prescaler. The write has priority over a same-cycle increment.
  - TDIV_CNT reads the prescaler value.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..7 and wraps 7 -> 0.
  - dig_en = ~(1 << index).
  - seg = hex decode of DIG[4*index+3 : 4*index], with dp always off (bit7 = 1).
  - Decode table 0-F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - dig_en and seg are registered and update together, so there is no mixed digit/segment cycle.
  - A write to DIG does not reset the scan; the new nibble appears on the next registered update.
- LED: led = LED[23:0]; a write stores Bus_wdata[23:0].
- Reset asserted mid-operation restores all reset values on that edge. DRAM contents are untouched, and dram_wen is forced to 0 while cpu_rst=1.

Test Plan:
- Reset, then hold cpu_rst low -> led=0, dig_en=8'hFE, seg=8'hC0, TIMER reads 0, Bus_rdata for unmapped 0xFFFFF100 = 0.
- Write 0x00ABCDEF to 0xFFFFF060 -> led=24'hABCDEF next edge; same-cycle read returns 0, next-cycle read returns 0x00ABCDEF; dram_wen stays 0 throughout.
- Bus_addr=0x00000010, Bus_wen=1, data 0x12345678 -> dram_wen=1, dram_addr=14'h0004; read with dram_rdata=0xDEADBEEF -> Bus_rdata=0xDEADBEEF.
- SCAN_DIV=4, DIG=0x0123ABCD:
  - dig_en steps FE,FD,FB,...,7F every 4 cycles, then wraps to FE.
  - seg sequence: A1,C6,83,88,B0,A4,F9,C0.
- TIMER_DIV=3:
  - Write TIMER=0xFFFFFFFE -> after 3 cycles reads 0xFFFFFFFF, after 6 reads 0x00000000.
  - A write coinciding with an increment edge loads the written value exactly.
- sw toggled to 0x5A5A5A -> SW read still shows the old value one edge later and 0x005A5A5A after the second edge; btn=5'b10101 behaves the same way on BTN.

Source files
------------

// File: rtl/io_bus_bridge.sv
// ---------------------------------------------------------------------------
// io_bus_bridge : CPU data-bus decoder for DRAM, LEDs, switches, buttons,
//                 8-digit seven-segment scan and interval timer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_bus_bridge #(
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV  = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [31:0] TDIV_LAST = 32'(TIMER_DIV - 1);

  logic        io_space;
  logic        sel_dig;
  logic        sel_timer;
  logic        sel_tdiv;
  logic        sel_led;
  logic        sel_sw;
  logic        sel_btn;
  logic        wr_dig;
  logic        wr_timer;
  logic        wr_led;

  logic [31:0] dig_reg;
  logic [23:0] led_reg;
  logic [31:0] timer_reg;
  logic [31:0] presc;
  logic [23:0] sw_s1;
  logic [23:0] sw_s2;
  logic [4:0]  btn_s1;
  logic [4:0]  btn_s2;
  logic [31:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic [3:0]  cur_nibble;
  logic [7:0]  dig_en_reg;
  logic [7:0]  seg_reg;

  // The whole top 4 KiB page belongs to I/O; only exact matches hit a register.
  assign io_space  = (Bus_addr[31:12] == 20'hFFFFF);
  assign sel_dig   = (Bus_addr == ADDR_DIG);
  assign sel_timer = (Bus_addr == ADDR_TIMER);
  assign sel_tdiv  = (Bus_addr == ADDR_TDIV);
  assign sel_led   = (Bus_addr == ADDR_LED);
  assign sel_sw    = (Bus_addr == ADDR_SW);
  assign sel_btn   = (Bus_addr == ADDR_BTN);

  assign wr_dig    = Bus_wen & sel_dig;
  assign wr_timer  = Bus_wen & sel_timer;
  assign wr_led    = Bus_wen & sel_led;

  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~io_space & ~cpu_rst;

  always_comb begin
    Bus_rdata = 32'h0000_0000;
    if (!io_space) begin
      Bus_rdata = dram_rdata;
    end else if (sel_dig) begin
      Bus_rdata = dig_reg;
    end else if (sel_timer) begin
      Bus_rdata = timer_reg;
    end else if (sel_tdiv) begin
      Bus_rdata = presc;
    end else if (sel_led) begin
      Bus_rdata = {8'h00, led_reg};
    end else if (sel_sw) begin
      Bus_rdata = {8'h00, sw_s2};
    end else if (sel_btn) begin
      Bus_rdata = {27'h0, btn_s2};
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_reg <= '0;
      led_reg <= '0;
    end else begin
      if (wr_dig) begin
        dig_reg <= Bus_wdata;
      end
      if (wr_led) begin
        led_reg <= Bus_wdata[23:0];
      end
    end
  end

  // A CPU load wins over a coincident tick and restarts the prescale period.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      timer_reg <= '0;
      presc     <= '0;
    end else if (wr_timer) begin
      timer_reg <= Bus_wdata;
      presc     <= '0;
    end else if (presc == TDIV_LAST) begin
      timer_reg <= timer_reg + 32'd1;
      presc     <= '0;
    end else begin
      presc     <= presc + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + 32'd1;
    end
  end

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 8'hC0;
      4'h1:    hex_to_seg = 8'hF9;
      4'h2:    hex_to_seg = 8'hA4;
      4'h3:    hex_to_seg = 8'hB0;
      4'h4:    hex_to_seg = 8'h99;
      4'h5:    hex_to_seg = 8'h92;
      4'h6:    hex_to_seg = 8'h82;
      4'h7:    hex_to_seg = 8'hF8;
      4'h8:    hex_to_seg = 8'h80;
      4'h9:    hex_to_seg = 8'h90;
      4'hA:    hex_to_seg = 8'h88;
      4'hB:    hex_to_seg = 8'h83;
      4'hC:    hex_to_seg = 8'hC6;
      4'hD:    hex_to_seg = 8'hA1;
      4'hE:    hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  assign cur_nibble = dig_reg[{digit_idx, 2'b00} +: 4];

  // Enable and segments share one register stage so they never disagree.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_en_reg <= 8'hFE;
      seg_reg    <= 8'hC0;
    end else begin
      dig_en_reg <= ~(8'h01 << digit_idx);
      seg_reg    <= hex_to_seg(cur_nibble);
    end
  end

  assign led    = led_reg;
  assign dig_en = dig_en_reg;
  assign seg    = seg_reg;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_bus_bridge : scoreboard bench for io_bus_bridge.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_io_bus_bridge;

  localparam int SCAN_DIV  = 4;
  localparam int TIMER_DIV = 3;

  localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] A_TDIV  = 32'hFFFF_F024;
  localparam logic [31:0] A_LED   = 32'hFFFF_F060;
  localparam logic [31:0] A_SW    = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN   = 32'hFFFF_F078;
  localparam logic [31:0] A_UNMAP = 32'hFFFF_F100;

  localparam int K_RDATA = 0;
  localparam int K_WEN   = 1;
  localparam int K_DADDR = 2;
  localparam int K_WDATA = 3;
  localparam int K_LED   = 4;
  localparam int K_DIGEN = 5;
  localparam int K_SEG   = 6;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic [31:0] Bus_addr = '0;
  logic        Bus_wen = 1'b0;
  logic [31:0] Bus_wdata = '0;
  logic [31:0] Bus_rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  io_bus_bridge #(.SCAN_DIV(SCAN_DIV), .TIMER_DIV(TIMER_DIV)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata),
    .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .seg(seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  logic [31:0] tb_dram [16384];
  logic [31:0] ref_mem [16384];
  assign dram_rdata = tb_dram[dram_addr];
  always @(posedge cpu_clk) if (dram_wen) tb_dram[dram_addr] <= dram_wdata;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register values after k clock edges since the last reset.
  bit          mv = 1'b0;
  int          k = 0;
  int          load_k = 0;
  logic [31:0] load_val = '0;
  logic [31:0] dig_m = '0;
  logic [31:0] prev_dig = '0;
  logic [23:0] led_m = '0;
  logic [23:0] sw_p1 = '0;
  logic [23:0] sw_p2 = '0;
  logic [4:0]  btn_p1 = '0;
  logic [4:0]  btn_p2 = '0;
  logic [23:0] sw_v = '0;
  logic [4:0]  btn_v = '0;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] tab [16];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tab[v];
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_RDATA: return "Bus_rdata";
      K_WEN:   return "dram_wen";
      K_DADDR: return "dram_addr";
      K_WDATA: return "dram_wdata";
      K_LED:   return "led";
      K_DIGEN: return "dig_en";
      default: return "seg";
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int d;
    d = k - load_k;
    if (a[31:12] != 20'hFFFFF) return ref_mem[a[15:2]];
    case (a)
      A_DIG:   return dig_m;
      A_TIMER: return load_val + 32'(d / TIMER_DIV);
      A_TDIV:  return 32'(d % TIMER_DIV);
      A_LED:   return {8'h00, led_m};
      A_SW:    return {8'h00, sw_p2};
      A_BTN:   return {27'h0, btn_p2};
      default: return 32'h0;
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] e);
    exp_t it;
    it.cyc = cyc; it.kind = kind; it.exp = e;
    sb.push_back(it);
  endtask

  task automatic cycle(input logic rst, input logic [31:0] a, input logic wen,
                       input logic [31:0] wd);
    logic       is_dram;
    int         idx;
    logic [7:0] en_e;
    logic [7:0] seg_e;
    @(negedge cpu_clk);
    cpu_rst = rst; Bus_addr = a; Bus_wen = wen; Bus_wdata = wd; sw = sw_v; btn = btn_v;
    is_dram = (a[31:12] != 20'hFFFFF);
    push(K_WEN,   {31'b0, wen & is_dram & ~rst});
    push(K_DADDR, {18'b0, a[15:2]});
    push(K_WDATA, wd);
    if (mv) begin
      push(K_RDATA, model_read(a));
      push(K_LED, {8'h00, led_m});
      if (k == 0) begin
        en_e = 8'hFE; seg_e = 8'hC0;
      end else begin
        idx   = ((k - 1) / SCAN_DIV) % 8;
        en_e  = ~(8'h01 << idx);
        seg_e = hex7(prev_dig[idx*4 +: 4]);
      end
      push(K_DIGEN, {24'h0, en_e});
      push(K_SEG,   {24'h0, seg_e});
    end
    if (rst) begin
      mv = 1'b1; k = 0; load_k = 0; load_val = '0; dig_m = '0; prev_dig = '0;
      led_m = '0; sw_p1 = '0; sw_p2 = '0; btn_p1 = '0; btn_p2 = '0;
    end else if (mv) begin
      prev_dig = dig_m;
      sw_p2 = sw_p1; sw_p1 = sw_v; btn_p2 = btn_p1; btn_p1 = btn_v;
      if (wen) begin
        if (is_dram) ref_mem[a[15:2]] = wd;
        else begin
          case (a)
            A_DIG:   dig_m = wd;
            A_TIMER: begin load_val = wd; load_k = k + 1; end
            A_LED:   led_m = wd[23:0];
            default: ;
          endcase
        end
      end
      k = k + 1;
    end
  endtask

  task automatic rd(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, a, 1'b0, 32'h0);
  endtask

  // Monitor: every cycle, compare all expectations stamped for this cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge cpu_clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.kind)
          K_RDATA: act = Bus_rdata;
          K_WEN:   act = {31'b0, dram_wen};
          K_DADDR: act = {18'b0, dram_addr};
          K_WDATA: act = dram_wdata;
          K_LED:   act = {8'h00, led};
          K_DIGEN: act = {24'h0, dig_en};
          default: act = {24'h0, seg};
        endcase
        n_tests++;
        if (e.cyc != cyc || act !== e.exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h expected=%h (stamp %0d)",
                   kname(e.kind), cyc, act, e.exp, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return A_DIG;
      1: return A_TIMER;
      2: return A_TDIV;
      3: return A_LED;
      4: return A_SW;
      5: return A_BTN;
      6: return {20'hFFFFF, 12'($urandom)};
      default: return {1'b0, 15'($urandom), 10'b0, 4'($urandom), 2'($urandom)};
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    int          guard;
    for (int i = 0; i < 16384; i++) begin
      v = $urandom;
      tb_dram[i] = v;
      ref_mem[i] = v;
    end
    tb_dram[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    cycle(1'b1, A_UNMAP, 1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0010, 1'b1, 32'h1111_1111);
    rd(A_UNMAP, 1);
    rd(A_TIMER, 1);
    rd(A_LED, 1);

    cycle(1'b0, A_LED, 1'b1, 32'h00AB_CDEF);
    rd(A_LED, 2);

    cycle(1'b0, 32'h0000_0010, 1'b1, 32'h1234_5678);
    rd(32'h0000_0014, 1);
    rd(32'h0000_0010, 1);

    cycle(1'b0, A_DIG, 1'b1, 32'h0123_ABCD);
    rd(A_DIG, 40);

    cycle(1'b0, A_TIMER, 1'b1, 32'hFFFF_FFFE);
    rd(A_TIMER, 8);

    guard = 0;
    while ((k - load_k) % TIMER_DIV != TIMER_DIV - 1 && guard < 8) begin
      rd(A_TDIV, 1);
      guard++;
    end
    cycle(1'b0, A_TIMER, 1'b1, 32'h0000_0055);
    rd(A_TIMER, 4);

    sw_v = 24'h5A5A5A;
    rd(A_SW, 3);
    btn_v = 5'b10101;
    rd(A_BTN, 3);

    cycle(1'b1, 32'h0000_0020, 1'b1, 32'hCAFE_F00D);
    rd(A_LED, 2);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) sw_v = 24'($urandom);
      if ($urandom_range(0, 3) == 0) btn_v = 5'($urandom);
      cycle(($urandom_range(0, 299) == 0), rand_addr(), 1'($urandom), $urandom);
    end

    rd(A_UNMAP, 3);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
